// File: rtl/dsi_ctrl_pkg.sv
// Shared types and timing defaults for the DSI lane sequencer.
package dsi_ctrl_pkg;

   typedef enum logic [3:0] {
      DISABLED,
      IDLE,
      CLK_START,
      CLK_PRE,
      DATA_START,
      DATA_ACTIVE,
      DATA_FIN,
      CLK_POST,
      CLK_FIN
   } dsi_state_t;

   localparam logic [7:0] DEFAULT_T_CLK_PRE  = 8'd4;
   localparam logic [7:0] DEFAULT_T_CLK_POST = 8'd6;

endpackage

// File: rtl/dsi_timeout_counter.sv
// 8-bit down counter: reloaded on load, counts down while en, saturates at zero.
module dsi_timeout_counter (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] load_value,
   output logic       expired
);

   logic [7:0] count;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign expired = (count == 8'd0);

endmodule

// File: rtl/dsi_lanes_controller.sv
// Sequences the DSI clock lane and data lanes through one high-speed burst
// and streams packet beats from the assembler into the data lanes.
module dsi_lanes_controller
   import dsi_ctrl_pkg::*;
#(
   parameter int         LANES      = 4,
   parameter logic [7:0] T_CLK_PRE  = DEFAULT_T_CLK_PRE,
   parameter logic [7:0] T_CLK_POST = DEFAULT_T_CLK_POST
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [LANES*8-1:0] pkt_data,
   input  logic               pkt_valid,
   input  logic               pkt_last,
   output logic               pkt_ready,
   output logic               lines_enable,
   output logic               clk_start_rqst,
   output logic               clk_fin_rqst,
   input  logic               clk_active,
   output logic               data_start_rqst,
   output logic               data_fin_rqst,
   output logic [LANES*8-1:0] lanes_data,
   input  logic [LANES-1:0]   lanes_data_rqst,
   input  logic [LANES-1:0]   lanes_active,
   output logic               busy,
   output logic               underflow
);

   dsi_state_t state;
   dsi_state_t state_next;

   logic last_seen;
   logic in_data;
   logic all_rqst;
   logic split_rqst;
   logic take;
   logic accept;
   logic starve;
   logic pre_load;
   logic post_load;
   logic pre_expired;
   logic post_expired;

   logic lines_enable_d;
   logic busy_d;
   logic clk_start_d;
   logic clk_fin_d;
   logic data_start_d;
   logic data_fin_d;

   assign in_data    = (state == DATA_START) || (state == DATA_ACTIVE);
   assign all_rqst   = &lanes_data_rqst;
   assign split_rqst = (|lanes_data_rqst) && !all_rqst;
   assign take       = in_data && all_rqst;
   assign accept     = take && !last_seen && pkt_valid;
   assign starve     = take && !last_seen && !pkt_valid;
   assign pkt_ready  = take && !last_seen;

   assign pre_load   = (state_next == CLK_PRE)  && (state != CLK_PRE);
   assign post_load  = (state_next == CLK_POST) && (state != CLK_POST);

   dsi_timeout_counter u_pre_counter (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .load       (pre_load),
      .en         (state == CLK_PRE),
      .load_value (T_CLK_PRE),
      .expired    (pre_expired)
   );

   dsi_timeout_counter u_post_counter (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .load       (post_load),
      .en         (state == CLK_POST),
      .load_value (T_CLK_POST),
      .expired    (post_expired)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state <= DISABLED;
      end else begin
         state <= state_next;
      end
   end

   // A beat flagged last leaves the data phase right away, so a single-beat
   // burst can go straight from DATA_START to DATA_FIN.
   always_comb begin
      state_next = state;
      case (state)
         DISABLED:    if (enable) state_next = IDLE;
         IDLE: begin
            if (!enable) begin
               state_next = DISABLED;
            end else if (pkt_valid) begin
               state_next = CLK_START;
            end
         end
         CLK_START:   if (clk_active) state_next = CLK_PRE;
         CLK_PRE:     if (pre_expired) state_next = DATA_START;
         DATA_START: begin
            if (accept && pkt_last) begin
               state_next = DATA_FIN;
            end else if (take) begin
               state_next = DATA_ACTIVE;
            end
         end
         DATA_ACTIVE: if (last_seen || (accept && pkt_last)) state_next = DATA_FIN;
         DATA_FIN:    if (lanes_active == '0) state_next = CLK_POST;
         CLK_POST:    if (post_expired) state_next = CLK_FIN;
         CLK_FIN:     if (!clk_active) state_next = IDLE;
         default:     state_next = DISABLED;
      endcase
   end

   always_comb begin
      lines_enable_d = (state_next != DISABLED);
      busy_d         = (state_next != DISABLED) && (state_next != IDLE);
      clk_start_d    = (state_next == CLK_START);
      clk_fin_d      = (state_next == CLK_FIN);
      data_start_d   = (state_next == DATA_START);
      data_fin_d     = (state_next == DATA_FIN);
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         lines_enable    <= 1'b0;
         busy            <= 1'b0;
         clk_start_rqst  <= 1'b0;
         clk_fin_rqst    <= 1'b0;
         data_start_rqst <= 1'b0;
         data_fin_rqst   <= 1'b0;
      end else begin
         lines_enable    <= lines_enable_d;
         busy            <= busy_d;
         clk_start_rqst  <= clk_start_d;
         clk_fin_rqst    <= clk_fin_d;
         data_start_rqst <= data_start_d;
         data_fin_rqst   <= data_fin_d;
      end
   end

   // Starved request slots still hand the lanes a zero filler byte.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         lanes_data <= '0;
         last_seen  <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (accept) begin
            lanes_data <= pkt_data;
         end else if (starve) begin
            lanes_data <= '0;
         end

         if ((state_next == IDLE) && (state != IDLE)) begin
            last_seen <= 1'b0;
         end else if (accept && pkt_last) begin
            last_seen <= 1'b1;
         end

         if (starve || (in_data && split_rqst)) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule
